// File: rtl/h80bus_loader_pkg.sv
// Shared h80 bus command codes and the loader state encoding, visible to the
// loader and to any bench that wants to probe the loader state.
package h80bus_loader_pkg;

  localparam logic [2:0] bus_cmd_none    = 3'd0;
  localparam logic [2:0] bus_cmd_read_w  = 3'd1;
  localparam logic [2:0] bus_cmd_read_b  = 3'd2;
  localparam logic [2:0] bus_cmd_write_w = 3'd3;
  localparam logic [2:0] bus_cmd_write_b = 3'd4;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_HDR,
    LD_DATA,
    LD_WR,
    LD_CSUM
  } loader_state_t;

endpackage

// File: rtl/h80bus_loader.sv
// Framed byte stream to h80 bus byte-write master: SYNC, addr(2), len(2),
// payload, checksum. Each payload byte becomes one write_b cycle.
import h80bus_loader_pkg::*;

module h80bus_loader #(
  parameter int         BUS_ADDR_WIDTH = 16,
  parameter int         BUS_CMD_WIDTH  = 3,
  parameter int         BUS_DATA_WIDTH = 16,
  parameter logic [7:0] SYNC_BYTE      = 8'h55
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      ce_n,
  output logic [BUS_ADDR_WIDTH-1:0] addr,
  output logic [BUS_CMD_WIDTH-1:0]  cmd,
  inout  wire  [BUS_DATA_WIDTH-1:0] data_,
  input  logic                      wait_n,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  loader_state_t             state;
  logic [BUS_ADDR_WIDTH-1:0] addr_q;
  logic [15:0]               len_q;
  logic [7:0]                sum_q;
  logic [7:0]                byte_q;
  logic [1:0]                hdr_idx;
  logic [7:0]                csum_total;
  logic [15:0]               hdr_len;

  // Handshake: a byte moves at every rising edge where in_valid && in_ready.
  // in_ready depends only on registered state (and is forced low in reset).
  assign in_ready   = !reset && (state != LD_WR);
  assign ce_n       = (state != LD_WR);
  assign cmd        = (state == LD_WR) ? BUS_CMD_WIDTH'(bus_cmd_write_b) : '0;
  assign addr       = addr_q;
  assign data_      = (state == LD_WR) ? BUS_DATA_WIDTH'(byte_q) : 'z;
  assign csum_total = sum_q + in_data;
  assign hdr_len    = {in_data, len_q[7:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= LD_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      sum_q   <= '0;
      byte_q  <= '0;
      hdr_idx <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        LD_IDLE: begin
          if (in_valid && in_data == SYNC_BYTE) begin
            state   <= LD_HDR;
            err     <= 1'b0;
            busy    <= 1'b1;
            sum_q   <= '0;
            hdr_idx <= '0;
          end
        end
        LD_HDR: begin
          if (in_valid) begin
            hdr_idx <= hdr_idx + 2'd1;
            case (hdr_idx)
              2'd0: addr_q <= {addr_q[BUS_ADDR_WIDTH-1:8], in_data};
              2'd1: addr_q <= BUS_ADDR_WIDTH'({in_data, addr_q[7:0]});
              2'd2: len_q  <= {len_q[15:8], in_data};
              default: begin
                len_q <= hdr_len;
                state <= (hdr_len == 16'd0) ? LD_CSUM : LD_DATA;
              end
            endcase
          end
        end
        LD_DATA: begin
          if (in_valid) begin
            byte_q <= in_data;
            sum_q  <= sum_q + in_data;
            state  <= LD_WR;
          end
        end
        LD_WR: begin
          // A low wait_n simply holds everything; the cycle repeats unchanged.
          if (wait_n) begin
            addr_q <= addr_q + BUS_ADDR_WIDTH'(1);
            len_q  <= len_q - 16'd1;
            state  <= (len_q == 16'd1) ? LD_CSUM : LD_DATA;
          end
        end
        LD_CSUM: begin
          if (in_valid) begin
            err   <= (csum_total != 8'h00);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= LD_IDLE;
          end
        end
        default: state <= LD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_h80bus_loader.sv
// Bench for h80bus_loader: frames are built from a byte-level model, expected
// writes and frame results are queued, and a negedge monitor checks the bus.
import h80bus_loader_pkg::*;

module tb_h80bus_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  wire         in_ready;
  wire         ce_n;
  wire  [15:0] addr;
  wire  [2:0]  cmd;
  wire  [15:0] data_bus;
  logic        wait_n;
  wire         busy;
  wire         done;
  wire         err;

  h80bus_loader dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ce_n     (ce_n),
    .addr     (addr),
    .cmd      (cmd),
    .data_    (data_bus),
    .wait_n   (wait_n),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_q[$];   // {addr, byte} per expected write
  logic        err_q[$];   // expected err per frame end
  logic [7:0]  mem [logic [15:0]];
  logic [7:0]  payload[$];

  int          wait_mode = 0;  // 0 none, 1 random, 2 hold low, 3 targeted stall
  logic [15:0] stall_addr = 16'h0000;
  int          stall_left = 0;
  int          stall_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave wait generator, updated just after each rising edge.
  initial begin
    wait_n = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (wait_mode)
        0: wait_n = 1'b1;
        1: wait_n = ($urandom_range(0, 2) != 0);
        2: wait_n = 1'b0;
        default: begin
          if (!ce_n && addr == stall_addr && stall_left > 0) begin
            wait_n = 1'b0;
            stall_left--;
          end else begin
            wait_n = 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    int cnt;
    cnt = 0;
    in_data  = b;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      cnt++;
      if (cnt > 200) begin
        chk("accept_timeout", 32'(cnt), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    if ($urandom_range(0, 3) == 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends a complete frame carrying the bytes in payload; queues the
  // expected writes and the expected err result from plain arithmetic.
  task automatic send_frame(input logic [15:0] base, input logic bad);
    logic [7:0]  sum;
    logic [7:0]  csum;
    logic [15:0] len;
    sum = 8'h00;
    len = 16'(payload.size());
    foreach (payload[i]) begin
      exp_q.push_back({16'(base + 16'(i)), payload[i]});
      sum = sum + payload[i];
    end
    csum = 8'(8'h00 - sum) + {7'd0, bad};
    err_q.push_back(bad);
    send_byte(8'h55);
    chk("sync_clears_err", {31'd0, err}, 32'd0);
    chk("sync_sets_busy", {31'd0, busy}, 32'd1);
    send_byte(base[7:0]);
    send_byte(base[15:8]);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    foreach (payload[i]) send_byte(payload[i]);
    send_byte(csum);
    chk("frame_end_busy", {31'd0, busy}, 32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic        prev_stall;
    logic [15:0] prev_addr;
    logic [15:0] prev_data;
    logic [23:0] e;
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (!ce_n) begin
          chk("wr_cmd", {29'd0, cmd}, {29'd0, bus_cmd_write_b});
          chk("wr_in_ready", {31'd0, in_ready}, 32'd0);
          if (addr == stall_addr) stall_cycles++;
          if (prev_stall) begin
            chk("stall_addr", {16'd0, addr}, {16'd0, prev_addr});
            chk("stall_data", {16'd0, data_bus}, {16'd0, prev_data});
          end
          if (wait_n) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_write", {16'd0, addr}, 32'hFFFFFFFF);
            end else begin
              e = exp_q.pop_front();
              chk("write_addr", {16'd0, addr}, {16'd0, e[23:8]});
              chk("write_data", {16'd0, data_bus}, {24'd0, e[7:0]});
              mem[addr] = data_bus[7:0];
            end
            prev_stall = 1'b0;
          end else begin
            prev_stall = 1'b1;
            prev_addr  = addr;
            prev_data  = data_bus;
          end
        end else begin
          chk("idle_cmd", {29'd0, cmd}, 32'd0);
          if (prev_stall) chk("stall_ce_held", {31'd0, ce_n}, 32'd0);
          prev_stall = 1'b0;
        end
        if (done) begin
          if (err_q.size() == 0) begin
            chk("unexpected_done", {31'd0, done}, 32'd0);
          end else begin
            chk("frame_err", {31'd0, err}, {31'd0, err_q.pop_front()});
          end
          chk("done_busy", {31'd0, busy}, 32'd0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main stimulus ----------------
  initial begin
    logic [15:0] base;
    int          n;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_ce_n", {31'd0, ce_n}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_addr", {16'd0, addr}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Basic frame and memory read-back.
    payload = '{8'h11, 8'h22, 8'h33};
    send_frame(16'h1000, 1'b0);
    chk("readback_1000", {16'd0, mem[16'h1001], mem[16'h1000]}, 32'h2211);

    // Bad checksum: writes still happen, err stays until the next sync.
    payload = '{8'h11, 8'h22, 8'h33};
    send_frame(16'h1000, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("err_level_held", {31'd0, err}, 32'd1);

    // Three wait cycles on the second write.
    wait_mode    = 3;
    stall_addr   = 16'h2001;
    stall_left   = 3;
    stall_cycles = 0;
    payload = '{8'hA1, 8'hB2, 8'hC3};
    send_frame(16'h2000, 1'b0);
    chk("stall_wr_cycles", 32'(stall_cycles), 32'd4);
    stall_addr = 16'h0000;
    wait_mode  = 0;

    // Junk before sync, then a zero-length frame.
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h12);
    chk("junk_busy", {31'd0, busy}, 32'd0);
    payload = {};
    send_frame(16'h2000, 1'b0);

    // Address wrap.
    payload = '{8'hAA, 8'hBB};
    send_frame(16'hFFFF, 1'b0);
    chk("wrap_mem_ffff", {24'd0, mem[16'hFFFF]}, 32'hAA);
    chk("wrap_mem_0000", {24'd0, mem[16'h0000]}, 32'hBB);

    // Randomized frames with a random slave.
    wait_mode = 1;
    for (int f = 0; f < 8; f++) begin
      base = 16'($urandom);
      if (f == 0) base = 16'hFFFC;
      n = $urandom_range(1, 8);
      payload = {};
      for (int k = 0; k < n; k++) payload.push_back(8'($urandom));
      send_frame(base, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a stalled write.
    wait_mode = 2;
    send_byte(8'h55);
    send_byte(8'h00);
    send_byte(8'h30);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h77);
    @(negedge clk);
    chk("pre_reset_in_wr", {31'd0, ce_n}, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("midwr_rst_ce_n", {31'd0, ce_n}, 32'd1);
    chk("midwr_rst_busy", {31'd0, busy}, 32'd0);
    chk("midwr_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midwr_rst_cmd", {29'd0, cmd}, 32'd0);
    chk("midwr_rst_addr", {16'd0, addr}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    wait_mode = 1;
    @(posedge clk);
    #1;

    // Fresh frame after reset.
    payload = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(16'h4000, 1'b0);

    repeat (10) @(posedge clk);
    #1;
    chk("drain_writes", 32'(exp_q.size()), 32'd0);
    chk("drain_frames", 32'(err_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
